sigmoid_array: RTL and testbench

SIGMOID_ARRAY -- requirements
Module: sigmoid_array

---
 rtl/sigmoid_array.sv | 127 ++++++++++++
 tb/tb_sigmoid_array.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_array.sv
// sigmoid_array: stochastic-computing sigmoid over CHANNELS unipolar bitstreams.
// A shared LFSR makes a low-probability bias stream b. Each channel ANDs
// delayed copies of ~x to get k ~ (1-p)^N. A JK flip-flop (J=b, K=k) then settles
// at P(y) = pb / (pb + (1-p)^N). The ones in y are counted over fixed windows
// of enabled cycles.
module sigmoid_array #(
  parameter int         CHANNELS    = 4,
  parameter int         POWER       = 8,
  parameter logic [7:0] SEED        = 8'h54,
  parameter int         BIAS        = 5,
  parameter int         WINDOW_LOG2 = 8
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic                                en,
  input  logic                                gain_sel,
  input  logic [CHANNELS-1:0]                 x,
  output logic [CHANNELS-1:0]                 y,
  output logic [CHANNELS*(WINDOW_LOG2+1)-1:0] count,
  output logic                                count_valid
);

  localparam int                     CW       = WINDOW_LOG2 + 1;
  localparam int                     HALF     = POWER / 2;
  localparam logic [7:0]             BIAS_TH  = 8'(BIAS);
  localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;

  // Fibonacci step for x^8 + x^6 + x^5 + x^4 + 1 (taps at bits 7,5,4,3)
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // JK next state: set on J, clear on K, toggle on both, hold on neither
  function automatic logic jk_next(input logic j, input logic k, input logic q);
    return (j & ~q) | (~k & q);
  endfunction

  // ---- stage 0: shared LFSR / bias stream and per-channel ~x delay lines
  logic [7:0]          lfsr_p0;
  logic                bias_p0;
  logic [POWER-1:0]    s_p0 [CHANNELS];
  logic [CHANNELS-1:0] k_p0;

  // Shared LFSR advances once per enabled cycle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lfsr_p0 <= SEED;
    end else if (en) begin
      lfsr_p0 <= lfsr_step(lfsr_p0);
    end
  end

  assign bias_p0 = (lfsr_p0 < BIAS_TH);

  // Shift the complemented input into each channel's delay line
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int c = 0; c < CHANNELS; c++) s_p0[c] <= '0;
    end else if (en) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (POWER > 1) s_p0[c] <= {s_p0[c][POWER-2:0], ~x[c]};
        else           s_p0[c] <= ~x[c];
      end
    end
  end

  // Gain select picks how many delayed copies are ANDed; it acts at once, no flush
  always_comb begin
    k_p0 = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      k_p0[c] = gain_sel ? (&s_p0[c]) : (&s_p0[c][HALF-1:0]);
    end
  end

  // ---- stage 1: per-channel JK output flip-flops
  logic [CHANNELS-1:0] y_p1;

  // JK update with J = shared bias, K = channel product term
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      y_p1 <= '0;
    end else if (en) begin
      for (int c = 0; c < CHANNELS; c++) begin
        y_p1[c] <= jk_next(bias_p0, k_p0[c], y_p1[c]);
      end
    end
  end

  assign y = y_p1;

  // ---- stage 2: window counter, ones accumulators, count snapshot
  logic [WINDOW_LOG2-1:0] win_p2;
  logic [CW-1:0]          acc_p2 [CHANNELS];
  logic [CHANNELS*CW-1:0] count_p2;
  logic                   vld_p2;
  logic                   win_last;

  assign win_last = (win_p2 == WIN_LAST);

  // Accumulate y per window. On the last cycle, publish acc + y and restart at 0.
  // Reusing that cycle for the restart means no sample is lost.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_p2   <= '0;
      vld_p2   <= 1'b0;
      count_p2 <= '0;
      for (int c = 0; c < CHANNELS; c++) acc_p2[c] <= '0;
    end else begin
      vld_p2 <= en & win_last;
      if (en) begin
        win_p2 <= win_p2 + WINDOW_LOG2'(1);
        for (int c = 0; c < CHANNELS; c++) begin
          if (win_last) begin
            count_p2[c*CW +: CW] <= acc_p2[c] + CW'(y_p1[c]);
            acc_p2[c]            <= '0;
          end else begin
            acc_p2[c] <= acc_p2[c] + CW'(y_p1[c]);
          end
        end
      end
    end
  end

  assign count       = count_p2;
  assign count_valid = vld_p2;

endmodule

// File: tb/tb_sigmoid_array.sv
// Bench for sigmoid_array: three instances share clock, reset, en and gain_sel.
//   u_def : x = 1111, BIAS = 5   (k never fires, y latches to 1)
//   u_b0  : x = 0000, BIAS = 0   (b never fires, y stays 0)
//   u_b255: x = 1010, BIAS = 255 (channels 0/2 toggle, channels 1/3 latch to 1)
// A small reference model built from the LFSR polynomial and the JK truth table
// predicts y, count and count_valid every cycle. Directed checks pin the
// hand-derived window totals and pulse timing.
module tb_sigmoid_array;

  localparam int CH = 4;
  localparam int WL = 8;
  localparam int CW = WL + 1;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic n_rst = 1'b1;
  logic en = 1'b0;
  logic gain_sel = 1'b1;
  logic [CH-1:0] x_def = 4'b1111;
  logic [CH-1:0] x_b0  = 4'b0000;
  logic [CH-1:0] x_h   = 4'b1010;

  logic [CH-1:0]    y_def, y_b0, y_h;
  logic [CH*CW-1:0] cnt_def, cnt_b0, cnt_h;
  logic             cv_def, cv_b0, cv_h;

  always #5 if (clk_run) clk = ~clk;

  sigmoid_array #(.CHANNELS(CH), .POWER(8), .SEED(8'h54), .BIAS(5), .WINDOW_LOG2(WL)) u_def (
    .clk(clk), .n_rst(n_rst), .en(en), .gain_sel(gain_sel), .x(x_def),
    .y(y_def), .count(cnt_def), .count_valid(cv_def));

  sigmoid_array #(.CHANNELS(CH), .POWER(8), .SEED(8'h54), .BIAS(0), .WINDOW_LOG2(WL)) u_b0 (
    .clk(clk), .n_rst(n_rst), .en(en), .gain_sel(gain_sel), .x(x_b0),
    .y(y_b0), .count(cnt_b0), .count_valid(cv_b0));

  sigmoid_array #(.CHANNELS(CH), .POWER(8), .SEED(8'h54), .BIAS(255), .WINDOW_LOG2(WL)) u_b255 (
    .clk(clk), .n_rst(n_rst), .en(en), .gain_sel(gain_sel), .x(x_h),
    .y(y_h), .count(cnt_h), .count_valid(cv_h));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int at;

  logic [7:0]       lfsr_m;
  int               fill_m, win_m;
  logic [CH-1:0]    yd_m, y0_m, yh_m;
  int               accd [CH];
  int               acc0 [CH];
  int               acch [CH];
  logic [CH*CW-1:0] cnt_def_e, cnt_b0_e, cnt_h_e;
  logic             cv_e;
  logic             lfsr_nz;
  logic [7:0]       lfsr_snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_ref(input logic [7:0] s);
    logic fb;
    fb = ^(s & 8'b1011_1000);
    return {s[6:0], fb};
  endfunction

  function automatic logic jk(input logic j, input logic k, input logic q);
    case ({j, k})
      2'b10:   return 1'b1;
      2'b01:   return 1'b0;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  task automatic reset_model();
    lfsr_m = 8'h54;
    fill_m = 0;
    win_m  = 0;
    yd_m = '0; y0_m = '0; yh_m = '0;
    for (int c = 0; c < CH; c++) begin accd[c] = 0; acc0[c] = 0; acch[c] = 0; end
    cnt_def_e = '0; cnt_b0_e = '0; cnt_h_e = '0;
    cv_e = 1'b0;
  endtask

  task automatic check_all();
    chk("lfsr",     64'(u_def.lfsr_p0), 64'(lfsr_m));
    chk("y_def",    64'(y_def),   64'(yd_m));
    chk("y_b0",     64'(y_b0),    64'(y0_m));
    chk("y_b255",   64'(y_h),     64'(yh_m));
    chk("cv_def",   64'(cv_def),  64'(cv_e));
    chk("cv_b0",    64'(cv_b0),   64'(cv_e));
    chk("cv_b255",  64'(cv_h),    64'(cv_e));
    chk("cnt_def",  64'(cnt_def), 64'(cnt_def_e));
    chk("cnt_b0",   64'(cnt_b0),  64'(cnt_b0_e));
    chk("cnt_b255", 64'(cnt_h),   64'(cnt_h_e));
  endtask

  // One clock: capture pre-edge model inputs, let the edge pass, advance the model, compare
  task automatic tick();
    logic bd, bh, kz, kc;
    bd = (lfsr_m < 8'd5);
    bh = (lfsr_m < 8'd255);
    kz = gain_sel ? (fill_m >= 8) : (fill_m >= 4);
    @(posedge clk);
    #1;
    cyc++;
    cv_e = 1'b0;
    if (!n_rst) begin
      reset_model();
    end else if (en) begin
      for (int c = 0; c < CH; c++) begin
        accd[c] += int'(yd_m[c]);
        acc0[c] += int'(y0_m[c]);
        acch[c] += int'(yh_m[c]);
      end
      if (win_m == 255) begin
        cv_e = 1'b1;
        win_m = 0;
        for (int c = 0; c < CH; c++) begin
          cnt_def_e[c*CW +: CW] = CW'(accd[c]);
          cnt_b0_e[c*CW +: CW]  = CW'(acc0[c]);
          cnt_h_e[c*CW +: CW]   = CW'(acch[c]);
          accd[c] = 0; acc0[c] = 0; acch[c] = 0;
        end
      end else begin
        win_m++;
      end
      for (int c = 0; c < CH; c++) begin
        kc = x_h[c] ? 1'b0 : kz;
        yd_m[c] = jk(bd, 1'b0, yd_m[c]);
        y0_m[c] = jk(1'b0, kz, y0_m[c]);
        yh_m[c] = jk(bh, kc, yh_m[c]);
      end
      lfsr_m = lfsr_ref(lfsr_m);
      if (fill_m < 8) fill_m++;
    end
    check_all();
  endtask

  task automatic run_to_cv(input int limit, output int hit);
    hit = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (cv_def === 1'b1) begin
        hit = cyc;
        break;
      end
    end
  endtask

  initial begin
    reset_model();

    // Asynchronous reset with the clock stopped
    #2 n_rst = 1'b0;
    #1;
    check_all();
    chk("reset_lfsr_seed", 64'(u_def.lfsr_p0), 64'h54);

    // Start the clock, hold reset two edges, release between edges
    #1 clk_run = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    en = 1'b1;
    cyc = 0;

    // Window 1: full LFSR period; gain_sel drops to 0 while delay lines are half full
    lfsr_nz = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      if (i == 6)  gain_sel = 1'b0;
      if (i == 40) gain_sel = 1'b1;
      tick();
      if (u_def.lfsr_p0 == 8'h00) lfsr_nz = 1'b0;
    end
    chk("lfsr_period_255", 64'(u_def.lfsr_p0), 64'h54);
    chk("lfsr_never_zero", 64'(lfsr_nz), 64'h1);

    run_to_cv(10, at);
    chk("cv_first_window_cycle", 64'(at), 64'd256);
    chk("b255_ch1_window1", 64'(cnt_h[CW +: CW]), 64'd255);

    // Window 2: every steady channel saturates or stays silent
    run_to_cv(300, at);
    chk("cv_second_window_cycle", 64'(at), 64'd512);
    chk("def_window2_all_256", 64'(cnt_def), 64'({4{9'd256}}));
    chk("b0_window2_all_0", 64'(cnt_b0), 64'd0);
    chk("b255_ch3_ch1_window2", 64'({cnt_h[3*CW +: CW], cnt_h[CW +: CW]}), 64'({9'd256, 9'd256}));

    // Window 3: 10-cycle stall mid-window freezes everything and delays the pulse
    for (int i = 0; i < 100; i++) tick();
    en = 1'b0;
    lfsr_snap = lfsr_m;
    for (int i = 0; i < 10; i++) tick();
    chk("stall_lfsr_frozen", 64'(u_def.lfsr_p0), 64'(lfsr_snap));
    en = 1'b1;
    run_to_cv(300, at);
    chk("cv_after_stall_cycle", 64'(at), 64'd778);

    // Window 4: reset mid-window discards the partial window
    for (int i = 0; i < 50; i++) tick();
    #1 n_rst = 1'b0;
    #1;
    reset_model();
    check_all();
    chk("midwin_reset_lfsr", 64'(u_def.lfsr_p0), 64'h54);
    tick();
    tick();
    n_rst = 1'b1;
    cyc = 0;
    run_to_cv(300, at);
    chk("cv_after_reset_cycle", 64'(at), 64'd256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
